rob_param: RTL and testbench
============================

# rob_param

Parametrised reorder buffer for the out-of-order RV32I core: a circular buffer of DEPTH entries with NUM_WB writeback (CDB) channels. It sits between dispatch and the architectural register file and commits one instruction per cycle in program order. It flushes on a committed branch redirect, and serves two operand-lookup ports to dispatch. It generalises the fixed 32-entry, 5-bit-index ROB to any power-of-two depth and any channel count.

## Interface
Parameters:
- DEPTH, 32, entry count; power of two, ≥4; IDX_W = $clog2(DEPTH) (localparam)
- NUM_WB, 4, writeback channels (alu, mul, br, mem by default)

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- alloc_valid / alloc_ready  in / out  1  dispatch handshake
- alloc_rd_addr, alloc_regf_we, alloc_op_type, alloc_pc  in  5, 1, types_t, 32  new entry fields
- alloc_idx  out  IDX_W  index assigned (tail)
- wb_valid  in  NUM_WB  per-channel writeback
- wb_idx, wb_data, wb_br_en, wb_pc_new  in  NUM_WB×IDX_W, ×32, ×1, ×32
- q1_idx, q2_idx  in  IDX_W  operand query
- q1_ready, q2_ready  out  1; q1_data, q2_data  out  32
- commit_valid / commit_ready  out / in  1  commit handshake
- commit_idx, commit_rd_addr, commit_regf_we, commit_data  out  IDX_W, 5, 1, 32
- flush  out  1; flush_pc  out  32
- count  out  IDX_W+1  occupancy

## Operation
- Head/tail pointers are IDX_W+1 bits (wrap bit). Full when indices are equal and wrap bits differ; empty when the pointers are equal.
- alloc_ready = rst_n && count<DEPTH && !flush. It does not depend on commit_ready; a full ROB refuses alloc even while committing.
- Alloc fire: entry[tail] valid=1, status=rob_wait, br_en=0; tail++; alloc_idx = tail index.
- WB: a channel whose idx hits a valid rob_wait entry sets status=done and stores data, br_en and pc_new. Hits on invalid or done entries are ignored. If two channels hit the same idx in one cycle, the highest channel number wins.
- Query: ready=1 when entry done, or when a same-cycle wb_valid matches the idx. A wb bypass takes priority (highest channel wins). If not ready, data = 0.
- Commit: commit_valid = head valid && status done. On handshake: entry invalidated, head++.
- Committing an entry with br_en=1 asserts flush=1 and flush_pc=pc_new in the same cycle (combinational). Next cycle all entries are invalid and tail=head (new head). Alloc and WB in the flush cycle are dropped.
- Wrap-around: index DEPTH-1 → 0 with wrap-bit toggle.

## Timing
- Reset: all entries invalid, head=tail=0, count=0. Outputs: commit_valid=0, flush=0, flush_pc=0, alloc_ready=0 while rst_n low, alloc_ready=1 first cycle after.
- Latencies:
  - Alloc in cycle N → entry visible from N+1; WB for it is legal from N+1.
  - WB in cycle M → commit_valid in M+1 (no WB→commit bypass).
  - Query is combinational.
- Reset asserted mid-operation clears everything at the next edge; in-flight handshakes are lost.

## Configuration
- ROB_RVFI_EN defined:
  - Each entry additionally stores the rob_mon_t monitor bundle (inst, rs1/rs2 addr+data, mem addr/masks/rdata/wdata).
  - Adds ports alloc_mon (in) and wb_mon (in, NUM_WB channels, same winner rule), plus commit_mon and commit_order (out, 64 bits).
  - commit_order resets to 0 and increments per commit.
- Undefined: none of those ports or storage exist.

## Structure
- Shared package rv32i_types holds status_t, types_t and rob_mon_t (fixed widths).
- Entry struct is declared inside the module (width depends on IDX_W).
- Sub-module rob_wb_merge: priority-merges NUM_WB channels into per-entry write enable + data, and serves the query bypass.

## Test plan
- Reset, then alloc 3 (idx 0,1,2), WB idx 1 then 0 → commits 0 then 1 in order; idx 2 held until WB arrives.
- DEPTH=4: alloc 4 → alloc_ready=0, count=4. Commit with alloc_valid=1 in the same cycle → alloc refused that cycle, accepted the next.
- Ptr wrap: 6 alloc/commit pairs at DEPTH=4 → alloc_idx sequence 0,1,2,3,0,1; count never exceeds 4.
- Branch idx 1 WB br_en=1, pc_new=0x1000_0040, entries 2-3 pending → flush=1, flush_pc=0x1000_0040 on commit of 1. Next cycle count=0 and tail=head=2.
- Channels 0 and 3 write idx 2 same cycle (data 0x11, 0x33) → stored 0x33; q1_idx=2 in that cycle → q1_ready=1, q1_data=0x33.
- rst_n low mid-stream with 3 entries done → next cycle count=0, commit_valid=0, alloc_idx=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types used by the reorder buffer: entry status, op class and
// the RVFI monitor bundle, plus a helper that folds writeback monitor data into an entry.
package rv32i_types;

  typedef enum logic {
    rob_wait = 1'b0,
    rob_done = 1'b1
  } status_t;

  typedef enum logic [2:0] {
    op_alu   = 3'd0,
    op_mul   = 3'd1,
    op_br    = 3'd2,
    op_load  = 3'd3,
    op_store = 3'd4,
    op_jump  = 3'd5
  } types_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rob_mon_t;

  // Instruction word and source register numbers are known at dispatch; everything
  // else is produced by the execution unit and arrives with the writeback.
  function automatic rob_mon_t mon_merge(rob_mon_t alloc_mon, rob_mon_t wb_mon);
    rob_mon_t m;
    m          = wb_mon;
    m.inst     = alloc_mon.inst;
    m.rs1_addr = alloc_mon.rs1_addr;
    m.rs2_addr = alloc_mon.rs2_addr;
    return m;
  endfunction

endpackage

// File: rtl/rob_param_if.sv
// Dispatch / writeback / commit bundle of the reorder buffer.
// Optional RVFI monitor signals exist only when ROB_RVFI_EN is defined.
interface rob_param_if #(
  parameter int DEPTH  = 32,
  parameter int NUM_WB = 4
);
  import rv32i_types::*;
  localparam int IDX_W = $clog2(DEPTH);

  logic                           alloc_valid;
  logic                           alloc_ready;
  logic [4:0]                     alloc_rd_addr;
  logic                           alloc_regf_we;
  types_t                         alloc_op_type;
  logic [31:0]                    alloc_pc;
  logic [IDX_W-1:0]               alloc_idx;

  logic [NUM_WB-1:0]              wb_valid;
  logic [NUM_WB-1:0][IDX_W-1:0]   wb_idx;
  logic [NUM_WB-1:0][31:0]        wb_data;
  logic [NUM_WB-1:0]              wb_br_en;
  logic [NUM_WB-1:0][31:0]        wb_pc_new;

  logic [IDX_W-1:0]               q1_idx;
  logic [IDX_W-1:0]               q2_idx;
  logic                           q1_ready;
  logic                           q2_ready;
  logic [31:0]                    q1_data;
  logic [31:0]                    q2_data;

  logic                           commit_valid;
  logic                           commit_ready;
  logic [IDX_W-1:0]               commit_idx;
  logic [4:0]                     commit_rd_addr;
  logic                           commit_regf_we;
  logic [31:0]                    commit_data;

  logic                           flush;
  logic [31:0]                    flush_pc;
  logic [IDX_W:0]                 count;

`ifdef ROB_RVFI_EN
  rob_mon_t                       alloc_mon;
  rob_mon_t [NUM_WB-1:0]          wb_mon;
  rob_mon_t                       commit_mon;
  logic [63:0]                    commit_order;
`endif

  modport master (
`ifdef ROB_RVFI_EN
    output alloc_mon, wb_mon,
    input  commit_mon, commit_order,
`endif
    output alloc_valid, alloc_rd_addr, alloc_regf_we, alloc_op_type, alloc_pc,
    output wb_valid, wb_idx, wb_data, wb_br_en, wb_pc_new,
    output q1_idx, q2_idx, commit_ready,
    input  alloc_ready, alloc_idx, q1_ready, q2_ready, q1_data, q2_data,
    input  commit_valid, commit_idx, commit_rd_addr, commit_regf_we, commit_data,
    input  flush, flush_pc, count
  );

  modport slave (
`ifdef ROB_RVFI_EN
    input  alloc_mon, wb_mon,
    output commit_mon, commit_order,
`endif
    input  alloc_valid, alloc_rd_addr, alloc_regf_we, alloc_op_type, alloc_pc,
    input  wb_valid, wb_idx, wb_data, wb_br_en, wb_pc_new,
    input  q1_idx, q2_idx, commit_ready,
    output alloc_ready, alloc_idx, q1_ready, q2_ready, q1_data, q2_data,
    output commit_valid, commit_idx, commit_rd_addr, commit_regf_we, commit_data,
    output flush, flush_pc, count
  );

endinterface

// File: rtl/rob_param_wb.sv
// rob_wb_merge: folds NUM_WB writeback channels into one write per ROB entry
// (highest channel wins) and provides the same-cycle operand bypass. Honours ROB_RVFI_EN.
module rob_wb_merge
  import rv32i_types::*;
#(
  parameter int DEPTH  = 32,
  parameter int NUM_WB = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [NUM_WB-1:0]             i_wb_valid,
  input  logic [NUM_WB-1:0][IDX_W-1:0]  i_wb_idx,
  input  logic [NUM_WB-1:0][31:0]       i_wb_data,
  input  logic [NUM_WB-1:0]             i_wb_br_en,
  input  logic [NUM_WB-1:0][31:0]       i_wb_pc_new,
`ifdef ROB_RVFI_EN
  input  rob_mon_t [NUM_WB-1:0]         i_wb_mon,
  output rob_mon_t [DEPTH-1:0]          o_mon,
`endif
  input  logic [IDX_W-1:0]              i_q1_idx,
  input  logic [IDX_W-1:0]              i_q2_idx,
  output logic [DEPTH-1:0]              o_we,
  output logic [DEPTH-1:0][31:0]        o_data,
  output logic [DEPTH-1:0]              o_br_en,
  output logic [DEPTH-1:0][31:0]        o_pc_new,
  output logic                          o_q1_hit,
  output logic                          o_q2_hit,
  output logic [31:0]                   o_q1_data,
  output logic [31:0]                   o_q2_data
);

  always_comb begin
    // NOTE: every output gets a default before the loops; a path that leaves one
    // unassigned would infer a latch.
    o_we     = '0;
    o_data   = '0;
    o_br_en  = '0;
    o_pc_new = '0;
`ifdef ROB_RVFI_EN
    o_mon    = '0;
`endif
    // Channels are scanned low to high, so a later match overwrites an earlier one.
    for (int e = 0; e < DEPTH; e++) begin
      for (int c = 0; c < NUM_WB; c++) begin
        if (i_wb_valid[c] && i_wb_idx[c] == IDX_W'(e)) begin
          o_we[e]     = 1'b1;
          o_data[e]   = i_wb_data[c];
          o_br_en[e]  = i_wb_br_en[c];
          o_pc_new[e] = i_wb_pc_new[c];
`ifdef ROB_RVFI_EN
          o_mon[e]    = i_wb_mon[c];
`endif
        end
      end
    end
  end

  always_comb begin
    o_q1_hit  = 1'b0;
    o_q2_hit  = 1'b0;
    o_q1_data = '0;
    o_q2_data = '0;
    for (int c = 0; c < NUM_WB; c++) begin
      if (i_wb_valid[c] && i_wb_idx[c] == i_q1_idx) begin
        o_q1_hit  = 1'b1;
        o_q1_data = i_wb_data[c];
      end
      if (i_wb_valid[c] && i_wb_idx[c] == i_q2_idx) begin
        o_q2_hit  = 1'b1;
        o_q2_data = i_wb_data[c];
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order commit of up to DEPTH in-flight instructions,
// NUM_WB writeback channels, branch-redirect flush. ROB_RVFI_EN adds monitor storage.
module rob_param
  import rv32i_types::*;
#(
  parameter int DEPTH  = 32,
  parameter int NUM_WB = 4
) (
  input logic       clk,
  input logic       rst_n,
  rob_param_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    status_t     status;
    logic [4:0]  rd_addr;
    logic        regf_we;
    types_t      op_type;
    logic [31:0] pc;
    logic [31:0] data;
    logic        br_en;
    logic [31:0] pc_new;
  } entry_t;

  logic [DEPTH-1:0]        r_valid;
  entry_t                  r_entry [DEPTH];
  logic [IDX_W:0]          r_head;
  logic [IDX_W:0]          r_tail;

  logic [IDX_W-1:0]        w_head_idx;
  logic [IDX_W-1:0]        w_tail_idx;
  logic                    w_full;
  logic                    w_alloc_fire;
  logic                    w_commit_fire;
  logic                    w_flush;
  entry_t                  w_head;
  logic [DEPTH-1:0]        w_we;
  logic [DEPTH-1:0][31:0]  w_data;
  logic [DEPTH-1:0]        w_br_en;
  logic [DEPTH-1:0][31:0]  w_pc_new;
  logic                    w_q1_hit;
  logic                    w_q2_hit;
  logic [31:0]             w_q1_byp;
  logic [31:0]             w_q2_byp;
  logic                    w_q1_done;
  logic                    w_q2_done;

`ifdef ROB_RVFI_EN
  rob_mon_t                r_mon [DEPTH];
  rob_mon_t [DEPTH-1:0]    w_mon;
  logic [63:0]             r_commit_order;
`endif

  rob_wb_merge #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) u_wb_merge (
    .i_wb_valid  (bus.wb_valid),
    .i_wb_idx    (bus.wb_idx),
    .i_wb_data   (bus.wb_data),
    .i_wb_br_en  (bus.wb_br_en),
    .i_wb_pc_new (bus.wb_pc_new),
`ifdef ROB_RVFI_EN
    .i_wb_mon    (bus.wb_mon),
    .o_mon       (w_mon),
`endif
    .i_q1_idx    (bus.q1_idx),
    .i_q2_idx    (bus.q2_idx),
    .o_we        (w_we),
    .o_data      (w_data),
    .o_br_en     (w_br_en),
    .o_pc_new    (w_pc_new),
    .o_q1_hit    (w_q1_hit),
    .o_q2_hit    (w_q2_hit),
    .o_q1_data   (w_q1_byp),
    .o_q2_data   (w_q2_byp)
  );

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_head     = r_entry[w_head_idx];

  assign bus.commit_valid   = r_valid[w_head_idx] && (w_head.status == rob_done);
  assign w_commit_fire      = bus.commit_valid && bus.commit_ready;
  assign w_flush            = w_commit_fire && w_head.br_en;
  assign bus.alloc_ready    = rst_n && !w_full && !w_flush;
  assign w_alloc_fire       = bus.alloc_valid && bus.alloc_ready;

  assign bus.alloc_idx      = w_tail_idx;
  assign bus.count          = r_tail - r_head;
  assign bus.commit_idx     = w_head_idx;
  assign bus.commit_rd_addr = w_head.rd_addr;
  assign bus.commit_regf_we = w_head.regf_we;
  assign bus.commit_data    = w_head.data;
  assign bus.flush          = w_flush;
  assign bus.flush_pc       = w_flush ? w_head.pc_new : 32'h0;

  // A same-cycle writeback overrides whatever the entry already holds.
  assign w_q1_done    = r_valid[bus.q1_idx] && (r_entry[bus.q1_idx].status == rob_done);
  assign w_q2_done    = r_valid[bus.q2_idx] && (r_entry[bus.q2_idx].status == rob_done);
  assign bus.q1_ready = w_q1_hit || w_q1_done;
  assign bus.q2_ready = w_q2_hit || w_q2_done;
  assign bus.q1_data  = w_q1_hit ? w_q1_byp : (w_q1_done ? r_entry[bus.q1_idx].data : 32'h0);
  assign bus.q2_data  = w_q2_hit ? w_q2_byp : (w_q2_done ? r_entry[bus.q2_idx].data : 32'h0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
    end else if (w_flush) begin
      // The redirecting branch itself retires; everything younger is discarded.
      r_head  <= r_head + 1'b1;
      r_tail  <= r_head + 1'b1;
      r_valid <= '0;
    end else begin
      if (w_alloc_fire)  r_tail <= r_tail + 1'b1;
      if (w_commit_fire) r_head <= r_head + 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
        if (w_alloc_fire && w_tail_idx == IDX_W'(e))
          r_valid[e] <= 1'b1;
        else if (w_commit_fire && w_head_idx == IDX_W'(e))
          r_valid[e] <= 1'b0;
      end
    end
  end

  // NOTE: the payload array has no reset; r_valid alone decides whether an entry is
  // live, so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_alloc_fire && w_tail_idx == IDX_W'(e)) begin
        r_entry[e].status  <= rob_wait;
        r_entry[e].rd_addr <= bus.alloc_rd_addr;
        r_entry[e].regf_we <= bus.alloc_regf_we;
        r_entry[e].op_type <= bus.alloc_op_type;
        r_entry[e].pc      <= bus.alloc_pc;
        r_entry[e].br_en   <= 1'b0;
`ifdef ROB_RVFI_EN
        r_mon[e]           <= bus.alloc_mon;
`endif
      end else if (!w_flush && w_we[e] && r_valid[e] && r_entry[e].status == rob_wait) begin
        r_entry[e].status  <= rob_done;
        r_entry[e].data    <= w_data[e];
        r_entry[e].br_en   <= w_br_en[e];
        r_entry[e].pc_new  <= w_pc_new[e];
`ifdef ROB_RVFI_EN
        r_mon[e]           <= mon_merge(r_mon[e], w_mon[e]);
`endif
      end
    end
  end

`ifdef ROB_RVFI_EN
  always_ff @(posedge clk) begin
    if (!rst_n)             r_commit_order <= '0;
    else if (w_commit_fire) r_commit_order <= r_commit_order + 64'd1;
  end

  assign bus.commit_mon   = r_mon[w_head_idx];
  assign bus.commit_order = r_commit_order;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Directed self-checking bench for rob_param at DEPTH=4, NUM_WB=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_rob_param;
  import rv32i_types::*;

  localparam int DEPTH  = 4;
  localparam int NUM_WB = 4;
  localparam int IDX_W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rob_param_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) bus ();

  rob_param #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    bus.wb_valid  = '0;
    bus.wb_idx    = '0;
    bus.wb_data   = '0;
    bus.wb_br_en  = '0;
    bus.wb_pc_new = '0;
`ifdef ROB_RVFI_EN
    bus.wb_mon    = '0;
`endif
  endtask

  task automatic clear_inputs();
    bus.alloc_valid   = 1'b0;
    bus.alloc_rd_addr = 5'd0;
    bus.alloc_regf_we = 1'b1;
    bus.alloc_op_type = op_alu;
    bus.alloc_pc      = 32'h0000_1000;
    bus.q1_idx        = '0;
    bus.q2_idx        = '0;
    bus.commit_ready  = 1'b0;
`ifdef ROB_RVFI_EN
    bus.alloc_mon     = '0;
`endif
    clear_wb();
  endtask

  task automatic drive_wb(input int ch, input logic [IDX_W-1:0] idx, input logic [31:0] data,
                          input logic br_en, input logic [31:0] pc_new);
    bus.wb_valid[ch]  = 1'b1;
    bus.wb_idx[ch]    = idx;
    bus.wb_data[ch]   = data;
    bus.wb_br_en[ch]  = br_en;
    bus.wb_pc_new[ch] = pc_new;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n);
    bus.alloc_valid = 1'b1;
    repeat (n) tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.alloc_valid = 1'b1;
    tick();
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_alloc_ready: got %b want 0", bus.alloc_ready); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %b want 0", bus.commit_valid); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    checks++; if (bus.flush_pc !== 32'h0) begin errors++; $display("FAIL reset_flush_pc: got %h want 0", bus.flush_pc); end
    rst_n = 1'b1;
    bus.alloc_valid = 1'b0;
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL post_reset_alloc_ready: got %b want 1", bus.alloc_ready); end
    tick();
  endtask

  task automatic test_in_order();
    reset_dut();
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alloc_rd_addr = 5'(i + 1);
      #1;
      checks++; if (bus.alloc_idx !== 2'(i)) begin errors++; $display("FAIL inorder_alloc_idx%0d: got %0d want %0d", i, bus.alloc_idx, i); end
      tick();
    end
    bus.alloc_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL inorder_count3: got %0d want 3", bus.count); end
    drive_wb(0, 2'd1, 32'h0000_00A1, 1'b0, 32'h0);
    tick();
    clear_wb();
    #1;
    checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL inorder_head_wait: got %b want 0", bus.commit_valid); end
    drive_wb(1, 2'd0, 32'h0000_00A0, 1'b0, 32'h0);
    tick();
    clear_wb();
    bus.commit_ready = 1'b1;
    #1;
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 2'd0) begin errors++; $display("FAIL inorder_commit0: got v=%b idx=%0d want v=1 idx=0", bus.commit_valid, bus.commit_idx); end
    checks++; if (bus.commit_data !== 32'hA0 || bus.commit_rd_addr !== 5'd1 || bus.commit_regf_we !== 1'b1) begin errors++; $display("FAIL inorder_commit0_fields: got data=%h rd=%0d we=%b want data=a0 rd=1 we=1", bus.commit_data, bus.commit_rd_addr, bus.commit_regf_we); end
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 2'd1 || bus.commit_data !== 32'hA1) begin errors++; $display("FAIL inorder_commit1: got v=%b idx=%0d data=%h want v=1 idx=1 data=a1", bus.commit_valid, bus.commit_idx, bus.commit_data); end
    tick();
    checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 3'd1) begin errors++; $display("FAIL inorder_idx2_held: got v=%b count=%0d want v=0 count=1", bus.commit_valid, bus.count); end
    drive_wb(3, 2'd2, 32'h0000_00A2, 1'b0, 32'h0);
    tick();
    clear_wb();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_data !== 32'hA2) begin errors++; $display("FAIL inorder_commit2: got v=%b data=%h want v=1 data=a2", bus.commit_valid, bus.commit_data); end
    tick();
    bus.commit_ready = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL inorder_drained: got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    reset_dut();
    alloc_n(4);
    bus.alloc_valid = 1'b1;
    #1;
    checks++; if (bus.count !== 3'd4 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d ready=%b want count=4 ready=0", bus.count, bus.alloc_ready); end
    drive_wb(2, 2'd0, 32'h0000_0BEE, 1'b0, 32'h0);
    tick();
    clear_wb();
    bus.commit_ready = 1'b1;
    #1;
    checks++; if (bus.commit_valid !== 1'b1 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_commit_no_alloc: got cv=%b ready=%b want cv=1 ready=0", bus.commit_valid, bus.alloc_ready); end
    tick();
    bus.commit_ready = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd3 || bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 2'd0) begin errors++; $display("FAIL full_after_commit: got count=%0d ready=%b idx=%0d want 3 1 0", bus.count, bus.alloc_ready, bus.alloc_idx); end
    tick();
    bus.alloc_valid = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", bus.count); end
  endtask

  task automatic test_wrap();
    logic [IDX_W-1:0] exp_seq [6];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      bus.alloc_valid = 1'b1;
      #1;
      checks++; if (bus.alloc_idx !== exp_seq[i]) begin errors++; $display("FAIL wrap_alloc_idx%0d: got %0d want %0d", i, bus.alloc_idx, exp_seq[i]); end
      tick();
      bus.alloc_valid = 1'b0;
      drive_wb(0, exp_seq[i], 32'(i), 1'b0, 32'h0);
      tick();
      clear_wb();
      bus.commit_ready = 1'b1;
      #1;
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== exp_seq[i]) begin errors++; $display("FAIL wrap_commit%0d: got v=%b idx=%0d want v=1 idx=%0d", i, bus.commit_valid, bus.commit_idx, exp_seq[i]); end
      checks++; if (bus.count > 3'd4) begin errors++; $display("FAIL wrap_count%0d: got %0d want <=4", i, bus.count); end
      tick();
      bus.commit_ready = 1'b0;
    end
  endtask

  task automatic test_flush();
    reset_dut();
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alloc_op_type = (i == 1) ? op_br : op_alu;
      tick();
    end
    bus.alloc_valid = 1'b0;
    drive_wb(0, 2'd0, 32'h0000_0010, 1'b0, 32'h0);
    drive_wb(2, 2'd1, 32'h0000_0014, 1'b1, 32'h1000_0040);
    tick();
    clear_wb();
    bus.commit_ready = 1'b1;
    #1;
    checks++; if (bus.commit_idx !== 2'd0 || bus.flush !== 1'b0) begin errors++; $display("FAIL flush_commit0: got idx=%0d flush=%b want idx=0 flush=0", bus.commit_idx, bus.flush); end
    tick();
    bus.alloc_valid = 1'b1;
    drive_wb(1, 2'd2, 32'h0000_0DEA, 1'b0, 32'h0);
    #1;
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 2'd1) begin errors++; $display("FAIL flush_commit1: got v=%b idx=%0d want v=1 idx=1", bus.commit_valid, bus.commit_idx); end
    checks++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h1000_0040) begin errors++; $display("FAIL flush_assert: got flush=%b pc=%h want 1 10000040", bus.flush, bus.flush_pc); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_alloc_blocked: got %b want 0", bus.alloc_ready); end
    tick();
    bus.commit_ready = 1'b0;
    bus.alloc_valid  = 1'b0;
    clear_wb();
    bus.q1_idx = 2'd2;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.alloc_idx !== 2'd2) begin errors++; $display("FAIL flush_after: got count=%0d tail=%0d want count=0 tail=2", bus.count, bus.alloc_idx); end
    checks++; if (bus.flush !== 1'b0 || bus.commit_valid !== 1'b0 || bus.q1_ready !== 1'b0) begin errors++; $display("FAIL flush_cleared: got flush=%b cv=%b q1r=%b want 0 0 0", bus.flush, bus.commit_valid, bus.q1_ready); end
  endtask

  task automatic test_wb_priority();
    reset_dut();
    alloc_n(3);
    drive_wb(0, 2'd2, 32'h0000_0011, 1'b0, 32'h0);
    drive_wb(3, 2'd2, 32'h0000_0033, 1'b0, 32'h0);
    bus.q1_idx = 2'd2;
    bus.q2_idx = 2'd1;
    #1;
    checks++; if (bus.q1_ready !== 1'b1 || bus.q1_data !== 32'h33) begin errors++; $display("FAIL prio_bypass: got r=%b d=%h want r=1 d=33", bus.q1_ready, bus.q1_data); end
    checks++; if (bus.q2_ready !== 1'b0 || bus.q2_data !== 32'h0) begin errors++; $display("FAIL prio_q2_wait: got r=%b d=%h want r=0 d=0", bus.q2_ready, bus.q2_data); end
    tick();
    clear_wb();
    #1;
    checks++; if (bus.q1_ready !== 1'b1 || bus.q1_data !== 32'h33) begin errors++; $display("FAIL prio_stored: got r=%b d=%h want r=1 d=33", bus.q1_ready, bus.q1_data); end
    drive_wb(1, 2'd2, 32'h0000_0055, 1'b0, 32'h0);
    #1;
    checks++; if (bus.q1_data !== 32'h55) begin errors++; $display("FAIL prio_bypass_over_done: got %h want 55", bus.q1_data); end
    tick();
    clear_wb();
    #1;
    checks++; if (bus.q1_data !== 32'h33) begin errors++; $display("FAIL prio_done_ignored: got %h want 33", bus.q1_data); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    alloc_n(3);
    drive_wb(0, 2'd0, 32'h1, 1'b0, 32'h0);
    drive_wb(1, 2'd1, 32'h2, 1'b0, 32'h0);
    drive_wb(2, 2'd2, 32'h3, 1'b0, 32'h0);
    tick();
    clear_wb();
    rst_n = 1'b0;
    bus.alloc_valid  = 1'b1;
    bus.commit_ready = 1'b1;
    #1;
    checks++; if (bus.commit_valid !== 1'b1 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL midrst_before: got cv=%b ready=%b want cv=1 ready=0", bus.commit_valid, bus.alloc_ready); end
    tick();
    rst_n = 1'b1;
    bus.alloc_valid  = 1'b0;
    bus.commit_ready = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0 || bus.commit_valid !== 1'b0 || bus.alloc_idx !== 2'd0) begin errors++; $display("FAIL midrst_after: got count=%0d cv=%b idx=%0d want 0 0 0", bus.count, bus.commit_valid, bus.alloc_idx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_wrap();
    test_flush();
    test_wb_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
